// File: rtl/adder_bist.sv
// adder_bist: built-in self-test wrapper for a combinational WIDTH-bit adder.
//
// Drives every operand vector {cin, a, b} to the adder under test. For each
// vector it waits SETTLE cycles, then compares the returned {cout, s} against
// a golden a+b+cin. It reports busy/done/pass/fail and the first failing
// vector.
//
// Parameters
//   WIDTH  : operand width; the vector index is 2*WIDTH+1 bits wide.
//   SETTLE : cycles each vector is held before sampling (minimum 1).
//
// Ports
//   clk, rst        : clock (rising edge), asynchronous active-high reset
//   start           : one-cycle pulse; starts a sweep when the block is idle
//   a, b, cin       : registered operands driven to the adder
//   s, cout         : adder result returned from the adder
//   busy            : a sweep is in progress
//   done            : the sweep has finished; stays set until the next start or rst
//   pass            : valid while done is set; 1 means no mismatch was seen
//   fail            : sticky; set on the first mismatch
//   vec             : current vector index, {cin, a, b}
//   err_a, err_b    : operands of the first failing vector
//   err_cin         : carry-in of the first failing vector
//   err_got         : {cout, s} captured at the first failure
//   err_cnt         : mismatch count, saturating (only with ADDER_BIST_CONT_EN)
//
// Build option
//   ADDER_BIST_CONT_EN : when defined, a mismatch does not stop the sweep, and
//                        the err_cnt output is added. When undefined, the sweep
//                        halts on the first mismatch.
module adder_bist #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [WIDTH-1:0]   a,
  output logic [WIDTH-1:0]   b,
  output logic               cin,
  input  logic [WIDTH-1:0]   s,
  input  logic               cout,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic               fail,
  output logic [2*WIDTH:0]   vec,
  output logic [WIDTH-1:0]   err_a,
  output logic [WIDTH-1:0]   err_b,
  output logic               err_cin,
  output logic [WIDTH:0]     err_got
`ifdef ADDER_BIST_CONT_EN
  ,
  output logic [2*WIDTH+1:0] err_cnt
`endif
);

  localparam int VW = 2*WIDTH + 1;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, FINISH} state_t;

  state_t          state, state_nxt;
  logic [SW-1:0]   settle_cnt;
  logic            mismatch;
  logic            vec_last;
  logic            halt;

  // Full-width golden sum; the carry is kept so a broken cout is caught.
  function automatic logic [WIDTH:0] golden_sum(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y,
                                                input logic             c);
    return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
  endfunction

  // The operands are simply the fields of the vector register, so they come
  // straight from flops. b is the inner loop and cin is the MSB.
  assign cin = vec[2*WIDTH];
  assign a   = vec[2*WIDTH-1:WIDTH];
  assign b   = vec[WIDTH-1:0];

  // 4-state compare: X/Z coming back from the adder must count as a failure.
  assign mismatch = ({cout, s} !== golden_sum(a, b, cin));
  assign vec_last = &vec;

`ifdef ADDER_BIST_CONT_EN
  assign halt = vec_last;
`else
  assign halt = mismatch | vec_last;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = DRIVE;
      DRIVE:   if (settle_cnt == SETTLE_LAST) state_nxt = CHECK;
      CHECK:   state_nxt = halt ? FINISH : DRIVE;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec        <= '0;
      settle_cnt <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail       <= 1'b0;
      err_a      <= '0;
      err_b      <= '0;
      err_cin    <= 1'b0;
      err_got    <= '0;
`ifdef ADDER_BIST_CONT_EN
      err_cnt    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            vec        <= '0;
            settle_cnt <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail       <= 1'b0;
            err_a      <= '0;
            err_b      <= '0;
            err_cin    <= 1'b0;
            err_got    <= '0;
`ifdef ADDER_BIST_CONT_EN
            err_cnt    <= '0;
`endif
          end
        end
        DRIVE: settle_cnt <= settle_cnt + SW'(1);
        CHECK: begin
          settle_cnt <= '0;
          // Only the first failure is recorded, even when the sweep continues.
          if (mismatch && !fail) begin
            fail    <= 1'b1;
            err_a   <= a;
            err_b   <= b;
            err_cin <= cin;
            err_got <= {cout, s};
          end
`ifdef ADDER_BIST_CONT_EN
          if (mismatch && (err_cnt != '1)) err_cnt <= err_cnt + (VW+1)'(1);
`endif
          if (!halt) vec <= vec + VW'(1);
        end
        FINISH: begin
          busy <= 1'b0;
          done <= 1'b1;
`ifdef ADDER_BIST_CONT_EN
          pass <= (err_cnt == '0);
`else
          pass <= ~fail;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_bist.sv
// Bench for adder_bist. It runs at WIDTH=4 and SETTLE=2 so that whole sweeps
// stay short. A fault-injectable behavioural adder sits between the BIST
// outputs and its inputs. For each sweep, a model predicts, cycle by cycle,
// what every output must show. It does this from the vector count and the set
// of mismatching vectors.
`timescale 1ns/1ps
module tb_adder_bist;
  localparam int W   = 4;
  localparam int ST  = 2;
  localparam int VW  = 2*W + 1;
  localparam int NV  = 1 << VW;
  localparam int CYC = ST + 1;
  localparam int OW  = 4 + VW + 2*W + 1 + 2*W + 1 + W + 1 + VW + 1;
  localparam logic [VW-1:0] XVEC = 9'h0A5;
`ifdef ADDER_BIST_CONT_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, start;
  logic [W-1:0] a, b, s;
  logic cin, cout, busy, done, pass, fail;
  logic [VW-1:0] vec;
  logic [W-1:0] err_a, err_b;
  logic err_cin;
  logic [W:0] err_got;
  logic [VW:0] cntv;
  int fault;

  int tests = 0;
  int fails = 0;

  // Model state for the current sweep.
  int pre [0:NV];
  int first_idx, last_v, fin;
  logic [W:0] first_got;

  always #5 clk = ~clk;

  // Behavioural adder with selectable faults:
  // 0 ideal, 1 s[3] stuck-at-0, 2 cout stuck-at-0, 3 cin ignored,
  // 4 all-X result at XVEC.
  function automatic logic [W:0] adder(input int f, input logic ci,
                                       input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] r;
    r = (W+1)'(x) + (W+1)'(y) + (W+1)'((f == 3) ? 1'b0 : ci);
    if (f == 1) r[3] = 1'b0;
    if (f == 2) r[W] = 1'b0;
    if (f == 4 && {ci, x, y} == XVEC) r = 'x;
    return r;
  endfunction

  assign {cout, s} = adder(fault, cin, a, b);

  adder_bist #(.WIDTH(W), .SETTLE(ST)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a(a), .b(b), .cin(cin), .s(s), .cout(cout),
    .busy(busy), .done(done), .pass(pass), .fail(fail), .vec(vec),
    .err_a(err_a), .err_b(err_b), .err_cin(err_cin), .err_got(err_got)
`ifdef ADDER_BIST_CONT_EN
    , .err_cnt(cntv)
`endif
  );
`ifndef ADDER_BIST_CONT_EN
  assign cntv = '0;
`endif

  wire [OW-1:0] obs = {busy, done, pass, fail, vec, a, b, cin,
                       err_a, err_b, err_cin, err_got, cntv};

  task automatic chkv(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h expected=%h", nm, got, exp);
    end
  endtask

  // Walk all vectors in sweep order. Record which ones the faulty adder gets
  // wrong, as a running count, and derive where the sweep must stop.
  task automatic build_model();
    logic [VW-1:0] v;
    logic [W:0] gold, got;
    pre[0] = 0;
    first_idx = -1;
    first_got = '0;
    for (int i = 0; i < NV; i++) begin
      v = VW'(i);
      gold = (W+1)'(v[2*W-1:W]) + (W+1)'(v[W-1:0]) + (W+1)'(v[2*W]);
      got  = adder(fault, v[2*W], v[2*W-1:W], v[W-1:0]);
      pre[i+1] = pre[i] + ((got !== gold) ? 1 : 0);
      if ((got !== gold) && first_idx < 0) begin
        first_idx = i;
        first_got = got;
      end
    end
    last_v = (first_idx >= 0 && !CONT) ? first_idx : NV - 1;
    fin    = (last_v + 1) * CYC + 2;
  endtask

  // Expected outputs after the n-th rising edge, counting the edge that
  // samples start as edge 1.
  function automatic logic [OW-1:0] exp_state(input int n);
    int k, chk, vv, nerr;
    logic [VW-1:0] v, fv;
    logic fl, bsy, dn, ps;
    logic [W:0] eg;
    k    = (n - 1) / CYC;
    chk  = (k > last_v + 1) ? last_v + 1 : k;
    vv   = (k > last_v) ? last_v : k;
    nerr = pre[chk];
    fl   = (nerr != 0);
    bsy  = (n < fin);
    dn   = (n >= fin);
    ps   = dn && (pre[last_v + 1] == 0);
    v    = VW'(vv);
    fv   = fl ? VW'(first_idx) : '0;
    eg   = fl ? first_got : '0;
    return {bsy, dn, ps, fl, v, v[2*W-1:W], v[W-1:0], v[2*W],
            fv[2*W-1:W], fv[W-1:0], fv[2*W], eg,
            CONT ? (VW+1)'(nerr) : (VW+1)'(0)};
  endfunction

  // One sweep. Outputs are compared on every falling edge. With poke set,
  // start is also pulsed mid-sweep and during the FINISH cycle. A nonzero
  // abort_n applies reset (together with start) at that cycle.
  task automatic run(input int f, input int abort_n, input bit poke);
    int n;
    fault = f;
    build_model();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 1;
    while (1) begin
      @(negedge clk);
      chkv($sformatf("f%0d_cyc%0d", f, n), 64'(obs), 64'(exp_state(n)));
      if (n == abort_n) begin
        #2 rst = 1'b1;
        start = 1'b1;
        #1 chkv("rst_async", 64'(obs), 64'(0));
        @(posedge clk);
        #1 chkv("rst_with_start", 64'(obs), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1 chkv("post_rst_idle", 64'(obs), 64'(0));
        return;
      end
      if (poke && (n == 20 || n == fin - 1)) start = 1'b1;
      if (n == fin + 1) break;
      @(posedge clk);
      #1 start = 1'b0;
      n++;
    end
  endtask

  initial begin
    logic [W:0] xv;
    xv = 'x;
    rst = 1'b1;
    start = 1'b0;
    fault = 0;
    repeat (3) @(posedge clk);
    #1 chkv("reset_state", 64'(obs), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // Ideal adder, with start pulses while busy and during FINISH.
    run(0, 0, 1'b1);
    chkv("ideal_fin", 64'(fin), 64'(1538));
    chkv("ideal_vec", 64'(vec), 64'(9'h1FF));
    chkv("ideal_pass", 64'({done, pass, fail}), 64'(3'b110));

    // s[3] stuck-at-0: first failure at a=0, b=8.
    run(1, 0, 1'b0);
    chkv("s3_first", 64'(first_idx), 64'(8));
    chkv("s3_err", 64'({err_cin, err_a, err_b, err_got}), 64'({1'b0, 4'h0, 4'h8, 5'h00}));
    chkv("s3_vec", 64'(vec), CONT ? 64'(9'h1FF) : 64'(9'h008));
    chkv("s3_pass", 64'({done, pass, fail}), 64'(3'b101));
    chkv("s3_cnt", 64'(cntv), CONT ? 64'(256) : 64'(0));

    // cout stuck-at-0: first failure at a=1, b=F (expected 0x10, got 0).
    run(2, 0, 1'b0);
    chkv("cout_err", 64'({err_cin, err_a, err_b, err_got}), 64'({1'b0, 4'h1, 4'hF, 5'h00}));
    chkv("cout_fin", 64'(fin), CONT ? 64'(1538) : 64'(98));

    // cin ignored: first failure at the first cin=1 vector.
    run(3, 0, 1'b0);
    chkv("cin_err", 64'({err_cin, err_a, err_b, err_got}), 64'({1'b1, 4'h0, 4'h0, 5'h00}));

    // Reset 50 cycles into a sweep, then a clean sweep.
    run(0, 50, 1'b0);
    run(0, 0, 1'b0);
    chkv("after_rst_pass", 64'({done, pass, fail}), 64'(3'b110));

    // X on the result counts as a mismatch.
    run(4, 0, 1'b0);
    chkv("x_vec", 64'({err_cin, err_a, err_b}), 64'(XVEC));
    chkv("x_got", 64'(err_got), 64'(xv));
    chkv("x_pass", 64'({done, pass, fail}), 64'(3'b101));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
